// File: rtl/eth_rx_frame_mon.sv
// Per-channel receive frame monitor: framing FSM, frame classification,
// saturating statistics counters, sticky/pulse error flags and a registered readout mux.
module eth_rx_frame_mon #(
    parameter int CH_COUNT = 2,
    parameter int CNT_W    = 32,
    parameter int LEN_W    = 16,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic [CH_COUNT-1:0] rx_tvalid,
    input  logic [CH_COUNT-1:0] rx_tuser,
    input  logic [CH_COUNT-1:0] rx_tlast,
    input  logic [CH_COUNT-1:0] rx_fr_good,
    input  logic [CH_COUNT-1:0] rx_fr_err,
    input  logic                cnt_clr,
    input  logic [1:0]          rd_ch,
    input  logic [2:0]          rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic [CH_COUNT-1:0] err_pulse,
    output logic [CH_COUNT-1:0] err_sticky,
    output logic                err_det
);

    localparam int NCNT    = 7;
    localparam int C_GOOD  = 0;
    localparam int C_BAD   = 1;
    localparam int C_RUNT  = 2;
    localparam int C_GIANT = 3;
    localparam int C_SEQ   = 4;
    localparam int C_FRERR = 5;
    localparam int C_BYTES = 6;
    localparam int SUM_W   = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    typedef enum logic {ST_IDLE = 1'b0, ST_FRAME = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {{(CNT_W-1){1'b0}}, n};
        sat_inc = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [LEN_W-1:0] n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(v) + SUM_W'(n);
        sat_add = (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic [CH_COUNT*NCNT*CNT_W-1:0] cnt_bus_s;
    logic [CH_COUNT-1:0]            pulse_bus_s;
    logic [CH_COUNT-1:0]            sticky_bus_s;
    logic [CNT_W-1:0]               rd_mux_s;
    logic [CNT_W-1:0]               rd_data_r;
    logic                           err_det_r;

    for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
        state_t           state_r, state_s;
        logic [LEN_W-1:0] len_r, len_s, len_inc_s, eval_len_s;
        logic             bad_acc_r, bad_acc_s;
        logic             sof_s, eof_s, eval_s, eval_acc_s, abort_s, seq_s;
        logic             runt_s, giant_s, bad_s, pulse_s, pulse_r, sticky_r;
        logic [CNT_W-1:0] cnt_r [NCNT];

        // Framing FSM next state and per-beat frame classification
        always_comb begin
            sof_s      = rx_tvalid[c] & rx_tuser[c];
            eof_s      = rx_tvalid[c] & rx_tlast[c];
            len_inc_s  = (&len_r) ? len_r : len_r + LEN_W'(1);
            state_s    = state_r;
            len_s      = len_r;
            bad_acc_s  = bad_acc_r | ((state_r == ST_FRAME) & rx_fr_err[c]);
            eval_s     = 1'b0;
            eval_len_s = len_inc_s;
            eval_acc_s = 1'b0;
            abort_s    = 1'b0;
            seq_s      = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sof_s) begin
                        len_s     = LEN_W'(1);
                        bad_acc_s = rx_fr_err[c];
                        if (eof_s) begin
                            eval_s     = 1'b1;
                            eval_len_s = LEN_W'(1);
                            eval_acc_s = rx_fr_err[c];
                        end else begin
                            state_s = ST_FRAME;
                        end
                    end else if (rx_tvalid[c]) begin
                        seq_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FRAME: begin
                    if (sof_s) begin
                        // new sof aborts the open frame and restarts framing
                        seq_s     = 1'b1;
                        abort_s   = 1'b1;
                        len_s     = LEN_W'(1);
                        bad_acc_s = rx_fr_err[c];
                        if (eof_s) begin
                            eval_s     = 1'b1;
                            eval_len_s = LEN_W'(1);
                            eval_acc_s = rx_fr_err[c];
                            state_s    = ST_IDLE;
                        end else begin
                            state_s = ST_FRAME;
                        end
                    end else if (eof_s) begin
                        eval_s     = 1'b1;
                        eval_len_s = len_inc_s;
                        eval_acc_s = bad_acc_r | rx_fr_err[c];
                        state_s    = ST_IDLE;
                    end else if (rx_tvalid[c]) begin
                        len_s = len_inc_s;
                    end else begin
                        len_s = len_r;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
            runt_s  = eval_s & (eval_len_s < MIN_L);
            giant_s = eval_s & (eval_len_s > MAX_L);
            bad_s   = eval_s & (~rx_fr_good[c] | runt_s | giant_s | eval_acc_s);
            pulse_s = rx_fr_err[c] | abort_s | bad_s;
        end

        // State, counters and flags; cnt_clr overrides any same-cycle increment
        always_ff @(posedge aclk) begin
            if (!areset_n) begin
                state_r   <= ST_IDLE;
                len_r     <= '0;
                bad_acc_r <= 1'b0;
                pulse_r   <= 1'b0;
                sticky_r  <= 1'b0;
                for (int k = 0; k < NCNT; k++) cnt_r[k] <= '0;
            end else begin
                state_r   <= state_s;
                len_r     <= len_s;
                bad_acc_r <= bad_acc_s;
                pulse_r   <= pulse_s;
                if (cnt_clr) begin
                    sticky_r <= 1'b0;
                    for (int k = 0; k < NCNT; k++) cnt_r[k] <= '0;
                end else begin
                    sticky_r       <= sticky_r | pulse_s;
                    cnt_r[C_GOOD]  <= sat_inc(cnt_r[C_GOOD], {1'b0, eval_s & ~bad_s});
                    cnt_r[C_BAD]   <= sat_inc(cnt_r[C_BAD], {1'b0, abort_s} + {1'b0, bad_s});
                    cnt_r[C_RUNT]  <= sat_inc(cnt_r[C_RUNT], {1'b0, runt_s});
                    cnt_r[C_GIANT] <= sat_inc(cnt_r[C_GIANT], {1'b0, giant_s});
                    cnt_r[C_SEQ]   <= sat_inc(cnt_r[C_SEQ], {1'b0, seq_s});
                    cnt_r[C_FRERR] <= sat_inc(cnt_r[C_FRERR], {1'b0, rx_fr_err[c]});
                    cnt_r[C_BYTES] <= (eval_s & ~bad_s) ? sat_add(cnt_r[C_BYTES], eval_len_s)
                                                        : cnt_r[C_BYTES];
                end
            end
        end

        assign pulse_bus_s[c]  = pulse_r;
        assign sticky_bus_s[c] = sticky_r;
        for (genvar k = 0; k < NCNT; k++) begin : g_pk
            assign cnt_bus_s[(c*NCNT+k)*CNT_W +: CNT_W] = cnt_r[k];
        end
    end

    // Readout select; unmatched channel or selector 7 leaves zero
    always_comb begin
        rd_mux_s = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            for (int k = 0; k < NCNT; k++) begin
                if (int'(rd_ch) == c && int'(rd_sel) == k) begin
                    rd_mux_s = cnt_bus_s[(c*NCNT+k)*CNT_W +: CNT_W];
                end else begin
                    rd_mux_s = rd_mux_s;
                end
            end
        end
    end

    // Registered readout and combined error detect
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            rd_data_r <= '0;
            err_det_r <= 1'b0;
        end else begin
            rd_data_r <= rd_mux_s;
            err_det_r <= |pulse_bus_s;
        end
    end

    assign rd_data    = rd_data_r;
    assign err_pulse  = pulse_bus_s;
    assign err_sticky = sticky_bus_s;
    assign err_det    = err_det_r;

endmodule

// File: tb/tb_eth_rx_frame_mon.sv
// Self-checking bench for eth_rx_frame_mon: directed frames from the test plan plus
// randomized beats, all checked cycle by cycle against a frame-level reference model.
module tb_eth_rx_frame_mon;

    localparam int CH   = 2;
    localparam int CW   = 8;
    localparam int LW   = 16;
    localparam int MINL = 64;
    localparam int MAXL = 1518;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LMAX = (1 << LW) - 1;

    logic          aclk = 1'b0;
    logic          areset_n;
    logic [CH-1:0] rx_tvalid, rx_tuser, rx_tlast, rx_fr_good, rx_fr_err;
    logic          cnt_clr;
    logic [1:0]    rd_ch;
    logic [2:0]    rd_sel;
    logic [CW-1:0] rd_data;
    logic [CH-1:0] err_pulse, err_sticky;
    logic          err_det;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: counters indexed [channel][GOOD,BAD,RUNT,GIANT,SEQ,FRERR,BYTES]
    int          cnt_m [CH][7];
    bit          in_frame_m [CH];
    int          len_m [CH];
    bit          acc_m [CH];
    logic [CH-1:0] pulse_m = '0;
    logic [CH-1:0] sticky_m = '0;
    logic          det_m = 1'b0;
    int          pulse_seen [CH];

    always #5 aclk = ~aclk;

    eth_rx_frame_mon #(
        .CH_COUNT(CH), .CNT_W(CW), .LEN_W(LW), .MIN_LEN(MINL), .MAX_LEN(MAXL)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .rx_tvalid(rx_tvalid), .rx_tuser(rx_tuser), .rx_tlast(rx_tlast),
        .rx_fr_good(rx_fr_good), .rx_fr_err(rx_fr_err),
        .cnt_clr(cnt_clr), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_data(rd_data), .err_pulse(err_pulse), .err_sticky(err_sticky), .err_det(err_det)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int rd_model(input int c, input int s);
        return (c < CH && s < 7) ? cnt_m[c][s] : 0;
    endfunction

    function automatic bit model_finish(input int c);
        bit runt, giant, bad;
        runt  = len_m[c] < MINL;
        giant = len_m[c] > MAXL;
        bad   = !rx_fr_good[c] || runt || giant || acc_m[c];
        if (runt)  cnt_m[c][2] = sat(cnt_m[c][2] + 1);
        if (giant) cnt_m[c][3] = sat(cnt_m[c][3] + 1);
        if (bad) begin
            cnt_m[c][1] = sat(cnt_m[c][1] + 1);
        end else begin
            cnt_m[c][0] = sat(cnt_m[c][0] + 1);
            cnt_m[c][6] = sat(cnt_m[c][6] + len_m[c]);
        end
        in_frame_m[c] = 1'b0;
        return bad;
    endfunction

    function automatic void model_step();
        logic [CH-1:0] p;
        p = '0;
        if (!areset_n) begin
            for (int c = 0; c < CH; c++) begin
                for (int s = 0; s < 7; s++) cnt_m[c][s] = 0;
                in_frame_m[c] = 1'b0;
                len_m[c] = 0;
                acc_m[c] = 1'b0;
            end
            pulse_m = '0; sticky_m = '0; det_m = 1'b0;
            return;
        end
        for (int c = 0; c < CH; c++) begin
            if (rx_fr_err[c]) begin
                cnt_m[c][5] = sat(cnt_m[c][5] + 1);
                p[c] = 1'b1;
            end
            if (rx_tvalid[c]) begin
                if (rx_tuser[c]) begin
                    if (in_frame_m[c]) begin
                        cnt_m[c][4] = sat(cnt_m[c][4] + 1);
                        cnt_m[c][1] = sat(cnt_m[c][1] + 1);
                        p[c] = 1'b1;
                    end
                    in_frame_m[c] = 1'b1;
                    len_m[c] = 1;
                    acc_m[c] = rx_fr_err[c];
                    if (rx_tlast[c] && model_finish(c)) p[c] = 1'b1;
                end else if (!in_frame_m[c]) begin
                    cnt_m[c][4] = sat(cnt_m[c][4] + 1);
                end else begin
                    len_m[c] = (len_m[c] >= LMAX) ? LMAX : len_m[c] + 1;
                    if (rx_fr_err[c]) acc_m[c] = 1'b1;
                    if (rx_tlast[c] && model_finish(c)) p[c] = 1'b1;
                end
            end else if (in_frame_m[c] && rx_fr_err[c]) begin
                acc_m[c] = 1'b1;
            end
            sticky_m[c] = sticky_m[c] | p[c];
        end
        if (cnt_clr) begin
            for (int c = 0; c < CH; c++) for (int s = 0; s < 7; s++) cnt_m[c][s] = 0;
            sticky_m = '0;
        end
        det_m   = |pulse_m;
        pulse_m = p;
    endfunction

    task automatic tick();
        int exp_rd;
        exp_rd = areset_n ? rd_model(int'(rd_ch), int'(rd_sel)) : 0;
        model_step();
        @(posedge aclk);
        #1;
        chk("err_pulse", 64'(err_pulse), 64'(pulse_m));
        chk("err_sticky", 64'(err_sticky), 64'(sticky_m));
        chk("err_det", 64'(err_det), 64'(det_m));
        chk("rd_data", 64'(rd_data), 64'(exp_rd));
        for (int c = 0; c < CH; c++) if (err_pulse[c]) pulse_seen[c]++;
    endtask

    task automatic idle();
        rx_tvalid = '0; rx_tuser = '0; rx_tlast = '0;
        rx_fr_good = '0; rx_fr_err = '0; cnt_clr = 1'b0;
    endtask

    task automatic beat(input int c, input bit sof, input bit eof, input bit good,
                        input bit fe, input bit clr);
        idle();
        rx_tvalid[c] = 1'b1; rx_tuser[c] = sof; rx_tlast[c] = eof;
        rx_fr_good[c] = good; rx_fr_err[c] = fe; cnt_clr = clr;
        tick();
        idle();
    endtask

    task automatic send_frame(input int c, input int n, input bit good, input int err_beat);
        for (int b = 1; b <= n; b++) beat(c, b == 1, b == n, good, b == err_beat, 1'b0);
    endtask

    task automatic clear_all();
        idle(); cnt_clr = 1'b1; tick(); idle();
    endtask

    task automatic chk_cnt(input string tag, input int c, input int s, input int exp);
        idle(); rd_ch = 2'(c); rd_sel = 3'(s);
        tick(); tick();
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic chk_model_all();
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 8; s++) begin
                idle(); rd_ch = 2'(c); rd_sel = 3'(s);
                tick(); tick();
                chk($sformatf("cnt[%0d][%0d]", c, s), 64'(rd_data), 64'(rd_model(c, s)));
            end
        end
    endtask

    initial begin
        idle(); rd_ch = 2'd0; rd_sel = 3'd0; areset_n = 1'b0;
        tick(); tick();
        areset_n = 1'b1;
        chk_model_all();
        chk_cnt("reset_good0", 0, 0, 0);

        // 64-beat good frame on ch0
        pulse_seen[0] = 0; pulse_seen[1] = 0;
        send_frame(0, 64, 1'b1, -1);
        chk("t1_no_pulse", 64'(pulse_seen[0]), 64'd0);
        chk_cnt("t1_good", 0, 0, 1);
        chk_cnt("t1_bytes", 0, 6, 64);
        chk_cnt("t1_bad", 0, 1, 0);

        // runt then giant on ch1
        clear_all();
        pulse_seen[1] = 0;
        send_frame(1, 10, 1'b1, -1);
        send_frame(1, 1600, 1'b1, -1);
        chk("t2_pulses", 64'(pulse_seen[1]), 64'd2);
        chk("t2_sticky", 64'(err_sticky[1]), 64'd1);
        chk_cnt("t2_runt", 1, 2, 1);
        chk_cnt("t2_giant", 1, 3, 1);
        chk_cnt("t2_bad", 1, 1, 2);

        // aborted frame then orphan beat on ch0
        clear_all();
        beat(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) beat(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(0, 70, 1'b1, -1);
        chk_cnt("t3_seq", 0, 4, 1);
        chk_cnt("t3_bad", 0, 1, 1);
        chk_cnt("t3_good", 0, 0, 1);
        chk_cnt("t3_bytes", 0, 6, 70);
        beat(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("t3_seq2", 0, 4, 2);

        // rx_fr_err mid-frame on ch1
        clear_all();
        pulse_seen[1] = 0;
        send_frame(1, 100, 1'b1, 50);
        chk("t4_pulses", 64'(pulse_seen[1]), 64'd2);
        chk_cnt("t4_frerr", 1, 5, 1);
        chk_cnt("t4_bad", 1, 1, 1);
        chk_cnt("t4_good", 1, 0, 0);

        // saturation, then clear coincident with a good eof
        clear_all();
        for (int f = 0; f < 300; f++) send_frame(0, 64, 1'b1, -1);
        chk_cnt("t5_good_sat", 0, 0, CMAX);
        chk_cnt("t5_bytes_sat", 0, 6, CMAX);
        beat(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 62; i++) beat(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        beat(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_sticky", 64'(err_sticky), 64'd0);
        chk_cnt("t5_good_clr", 0, 0, 0);
        chk_cnt("t5_bytes_clr", 0, 6, 0);
        chk_model_all();

        // reset mid-frame on both channels
        idle(); rx_tvalid = 2'b11; rx_tuser = 2'b11; tick();
        for (int i = 0; i < 29; i++) begin
            idle(); rx_tvalid = 2'b11; tick();
        end
        idle(); areset_n = 1'b0; tick();
        areset_n = 1'b1;
        send_frame(0, 64, 1'b1, -1);
        chk_cnt("t6_good0", 0, 0, 1);
        chk_cnt("t6_good1", 1, 0, 0);
        chk_cnt("t6_bad0", 0, 1, 0);
        chk_cnt("t6_ch3", 3, 0, 0);
        chk_cnt("t6_sel7", 0, 7, 0);

        // randomized beats on both channels
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < CH; c++) begin
                rx_tvalid[c]  = ($urandom_range(0, 3) != 0);
                rx_tuser[c]   = ($urandom_range(0, 59) == 0);
                rx_tlast[c]   = ($urandom_range(0, 69) == 0);
                rx_fr_good[c] = ($urandom_range(0, 7) != 0);
                rx_fr_err[c]  = ($urandom_range(0, 199) == 0);
            end
            cnt_clr = ($urandom_range(0, 999) == 0);
            rd_ch   = 2'($urandom_range(0, 3));
            rd_sel  = 3'($urandom_range(0, 7));
            tick();
        end
        chk_model_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_mon.md
Name: eth_rx_frame_mon

Overview:
- Parametrised per-port receive frame monitor and statistics block.
- Sits on the receive byte streams of up to CH_COUNT RGMII MACs, in the mac_gtx_clk domain. It replaces the ad-hoc two-port error-detect logic.
- Tracks frame framing per channel and classifies each frame as good, bad, runt, giant or sequence error. Keeps saturating counters, sticky flags and a combined error pulse, with a registered readout mux for debug or register access.

Parameters:
CH_COUNT, 2, number of monitored MAC receive channels (1..4)
CNT_W, 32, width of every statistics counter (8..48)
LEN_W, 16, width of the per-frame beat-length counter
MIN_LEN, 64, minimum legal frame length in beats (sof..eof inclusive)
MAX_LEN, 1518, maximum legal frame length in beats

Ports:
aclk  in  1  monitor clock (mac_gtx_clk)
areset_n  in  1  reset, synchronous, active-low
rx_tvalid  in  CH_COUNT  per-channel data beat valid
rx_tuser  in  CH_COUNT  start of frame, qualified by rx_tvalid
rx_tlast  in  CH_COUNT  end of frame, qualified by rx_tvalid
rx_fr_good  in  CH_COUNT  MAC FCS-good flag, sampled on the eof beat
rx_fr_err  in  CH_COUNT  MAC error pulse, any cycle, not qualified by valid
cnt_clr  in  1  synchronous clear of all counters and sticky flags
rd_ch  in  2  readout channel select
rd_sel  in  3  readout counter select
rd_data  out  CNT_W  selected counter value, registered
err_pulse  out  CH_COUNT  one-cycle pulse per bad frame or rx_fr_err
err_sticky  out  CH_COUNT  latched error per channel until cnt_clr
err_det  out  1  registered OR of all err_pulse bits

Behaviour:
- Reset (areset_n=0 at a rising aclk edge):
  - all counters, len, flags, rd_data, err_pulse, err_sticky and err_det go to 0; every FSM goes to IDLE.
  - Reset mid-frame abandons the frame; nothing is counted.
- Per-channel FSM, states IDLE and FRAME. Only beats with rx_tvalid=1 advance it:
  - IDLE, sof: go to FRAME, len=1, bad_acc=0.
  - IDLE, sof and eof on the same beat: evaluate a 1-beat frame, stay in IDLE.
  - IDLE, non-sof beat: SEQ++, stay in IDLE (orphan beat).
  - FRAME, plain beat: len++, saturating at all-ones.
  - FRAME, sof: SEQ++ and BAD++ for the aborted frame; restart with len=1 and stay in FRAME. If eof is also set on that beat, evaluate the new 1-beat frame.
  - FRAME, eof (no sof): final len = len+1; evaluate; go to IDLE.
- Evaluation on the eof beat:
  - runt = len<MIN_LEN; giant = len>MAX_LEN.
  - bad = ~rx_fr_good | runt | giant | bad_acc.
  - good frame: GOOD++ and BYTES += len.
  - bad frame: BAD++, plus RUNT++ and/or GIANT++ as applicable.
- rx_fr_err=1 in any cycle:
  - FRERR++ and err_pulse for that channel.
  - If the FSM is in FRAME, or the same cycle carries a sof, set bad_acc.
- Counters, each per channel, indexed by rd_sel: 0 GOOD, 1 BAD, 2 RUNT, 3 GIANT, 4 SEQ, 5 FRERR, 6 BYTES, 7 reserved (reads 0).
  - All counters saturate at 2^CNT_W-1 and never wrap. BYTES saturates rather than overflows on the add.
- Timing:
  - Event on a beat at cycle N: counter updated, err_pulse=1 and err_sticky=1 at N+1; err_det=1 at N+2.
  - err_pulse is asserted once per cycle even if a bad eof and rx_fr_err coincide, but both counters increment.
- cnt_clr=1:
  - all counters and err_sticky are 0 at the next edge. Clear wins over a simultaneous increment.
  - FSM state and len are not affected; the frame in progress is still evaluated and counted after the clear.
- Readout: rd_data at N+1 = counter[rd_ch][rd_sel] as registered at edge N. rd_ch>=CH_COUNT or rd_sel=7 returns 0.
- Channels are fully independent; simultaneous events on all channels are all counted in the same cycle.

Test Plan:
- Ch0: a 64-beat frame (sof on beat 1, eof on beat 64, rx_fr_good=1) -> GOOD=1, BYTES=64, BAD=0, err_pulse stays 0; rd_ch=0, rd_sel=6 reads 64 one cycle later.
- Ch1: a 10-beat frame with good=1, then a 1600-beat frame -> RUNT=1, GIANT=1, BAD=2; err_pulse[1] high for exactly one cycle after each eof; err_det follows one cycle later; err_sticky[1]=1.
- Ch0: sof, 20 beats, sof again, 70 beats, eof -> SEQ=1, BAD=1, GOOD=1, BYTES=70. A later orphan beat in IDLE -> SEQ=2.
- Ch1: rx_fr_err pulse mid-frame on a 100-beat frame with good=1 at eof -> FRERR=1, BAD=1, GOOD=0, two err_pulse events.
- CNT_W=8: 300 good 64-beat frames -> GOOD=255, BYTES=255. Then cnt_clr coincident with a good eof -> all counters read 0 and err_sticky=0.
- Assert areset_n=0 mid-frame on both channels, then release and send a good frame -> only the new frame is counted (GOOD=1); rd_ch=3 with CH_COUNT=2 reads 0.
